// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter that serialises 64-bit loads/stores into
// eight byte beats on a shared byte-wide memory port, with range checking.
module mem_access_arbiter #(
  parameter int MEM_BYTES = 64,
  parameter int MEM_AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [63:0]       req0_addr,
  input  logic [63:0]       req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [63:0]       rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [63:0]       req1_addr,
  input  logic [63:0]       req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [63:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [MEM_AW-1:0] LAST_BASE = MEM_AW'(MEM_BYTES - 8);

  state_t            state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic              last_q, last_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic              write_q, write_d, id_q, id_d, err_q, err_d;

  logic              gnt_vld, gnt_id, g_err;
  logic [63:0]       g_addr;

  // Favour the requester not granted last; last_q resets to 1 so req0 wins first.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = req1_valid & (~req0_valid | ~last_q);
    g_addr  = gnt_id ? req1_addr : req0_addr;
    g_err   = (g_addr[63:MEM_AW] != '0) || (g_addr[MEM_AW-1:0] > LAST_BASE);
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    write_d    = write_q;
    id_d       = id_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp0_rdata = '0;
    rsp0_err   = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_rdata = '0;
    rsp1_err   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          last_d     = gnt_id;
          id_d       = gnt_id;
          addr_d     = g_addr[MEM_AW-1:0];
          wdata_d    = gnt_id ? req1_wdata : req0_wdata;
          write_d    = gnt_id ? req1_write : req0_write;
          err_d      = g_err;
          rdata_d    = '0;
          beat_d     = '0;
          state_d    = g_err ? RESP : XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        mem_addr  = addr_q + MEM_AW'(beat_q);
        mem_we    = write_q;
        mem_re    = ~write_q;
        mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
        if (!write_q) rdata_d[{beat_q, 3'b000} +: 8] = mem_rdata;
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = RESP;
      end
      RESP: begin
        // rdata_q stays zero for stores and errors since it is cleared on grant.
        busy       = 1'b1;
        rsp0_valid = ~id_q;
        rsp0_rdata = id_q ? '0 : rdata_q;
        rsp0_err   = ~id_q & err_q;
        rsp1_valid = id_q;
        rsp1_rdata = id_q ? rdata_q : '0;
        rsp1_err   = id_q & err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every output in the same cycle, so an aborted beat never writes.
    if (reset) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp0_rdata = '0;
      rsp0_err   = 1'b0;
      rsp1_valid = 1'b0;
      rsp1_rdata = '0;
      rsp1_err   = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: transaction-level schedule model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_access_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [63:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [63:0] rsp0_rdata, rsp1_rdata;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];

  mem_access_arbiter #(.MEM_BYTES(64), .MEM_AW(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Transaction model: one outstanding access, beats at accept+1..+8, rsp at +9 (+1 on error).
  bit          act = 0, m_w, m_err, m_id, rr = 0;
  int          acc_c, rsp_c;
  logic [63:0] m_a, m_d, m_rd;

  always @(negedge clk) begin
    bit e_r0, e_r1, e_we, e_re, g, gv;
    int beat;
    logic [63:0] e_d0, e_d1;
    if (reset) begin
      chk("rst_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                          rsp1_err, mem_we, mem_re, busy}, '0);
      chk("rst_rdata", rsp0_rdata | rsp1_rdata, '0);
      act = 0; rr = 0;
    end else begin
      gv = 0; g = 0; e_r0 = 0; e_r1 = 0;
      if (!act && (req0_valid || req1_valid)) begin
        gv = 1;
        g  = req1_valid && (!req0_valid || rr);
        e_r0 = !g; e_r1 = g;
      end
      beat = cyc - acc_c - 1;
      e_we = act && !m_err && beat >= 0 && beat < 8 && m_w;
      e_re = act && !m_err && beat >= 0 && beat < 8 && !m_w;
      e_d0 = (act && cyc == rsp_c && !m_id) ? m_rd : 64'h0;
      e_d1 = (act && cyc == rsp_c &&  m_id) ? m_rd : 64'h0;
      chk("ready0", req0_ready, e_r0);
      chk("ready1", req1_ready, e_r1);
      chk("busy", busy, act);
      chk("mem_we", mem_we, e_we);
      chk("mem_re", mem_re, e_re);
      if (e_we || e_re) chk("mem_addr", mem_addr, m_a[5:0] + beat);
      if (e_we) chk("mem_wdata", mem_wdata, m_d[8*beat +: 8]);
      chk("rsp0_valid", rsp0_valid, act && cyc == rsp_c && !m_id);
      chk("rsp1_valid", rsp1_valid, act && cyc == rsp_c && m_id);
      chk("rsp0_err", rsp0_err, act && cyc == rsp_c && !m_id && m_err);
      chk("rsp1_err", rsp1_err, act && cyc == rsp_c && m_id && m_err);
      chk("rsp0_rdata", rsp0_rdata, e_d0);
      chk("rsp1_rdata", rsp1_rdata, e_d1);
      if (e_we) ref_mem[m_a[5:0] + beat] = m_d[8*beat +: 8];
      if (act && cyc == rsp_c) act = 0;
      if (gv) begin
        act   = 1; acc_c = cyc; m_id = g; rr = !g;
        m_w   = g ? req1_write : req0_write;
        m_a   = g ? req1_addr  : req0_addr;
        m_d   = g ? req1_wdata : req0_wdata;
        m_err = (m_a[63:6] != 0) || (m_a[5:0] > 56);
        rsp_c = cyc + (m_err ? 1 : 9);
        m_rd  = 0;
        if (!m_err && !m_w) for (int i = 0; i < 8; i++) m_rd[8*i +: 8] = ref_mem[m_a[5:0] + i];
      end
    end
  end

  task automatic drv(input bit id, input bit w, input logic [63:0] a, input logic [63:0] d,
                     output int acc);
    bit ok = 0;
    int n = 0;
    acc = -1;
    if (!id) begin req0_valid = 1; req0_write = w; req0_addr = a; req0_wdata = d; end
    else     begin req1_valid = 1; req1_write = w; req1_addr = a; req1_wdata = d; end
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = (id ? req1_ready : req0_ready) && !reset;
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else acc = cyc;
    @(posedge clk); #1;
    if (!id) req0_valid = 0; else req1_valid = 0;
  endtask

  // Called in the cycle after acceptance; k counts cycles up to the response.
  task automatic wait_rsp(input bit id, output int k, output logic [63:0] d, output bit e);
    bit seen = 0;
    k = 0; d = 'x; e = 1'bx;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (id ? rsp1_valid : rsp0_valid) begin
        seen = 1;
        d = id ? rsp1_rdata : rsp0_rdata;
        e = id ? rsp1_err : rsp0_err;
      end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int a0, a1, k;
    logic [63:0] d, mv;
    bit e;
    for (int i = 0; i < 64; i++) begin mem[i] = 8'(i); ref_mem[i] = 8'(i); end
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Load from preloaded memory.
    drv(0, 0, 64'd8, 0, a0);
    wait_rsp(0, k, d, e);
    chk("ld8_latency", k, 9);
    chk("ld8_data", d, 64'h0F0E0D0C0B0A0908);
    chk("ld8_err", e, 0);

    // Store then load back.
    drv(1, 1, 64'd16, 64'h1122334455667788, a1);
    wait_rsp(1, k, d, e);
    chk("st16_latency", k, 9);
    chk("st16_rdata", d, 0);
    for (int i = 0; i < 8; i++) mv[8*i +: 8] = mem[16 + i];
    chk("st16_mem", mv, 64'h1122334455667788);
    @(posedge clk); #1;
    drv(0, 0, 64'd16, 0, a0);
    wait_rsp(0, k, d, e);
    chk("ld16_data", d, 64'h1122334455667788);

    // Range errors respond in one cycle with no memory traffic.
    @(posedge clk); #1;
    drv(0, 0, 64'd60, 0, a0);
    wait_rsp(0, k, d, e);
    chk("err60_latency", k, 1);
    chk("err60_err", e, 1);
    chk("err60_rdata", d, 0);
    @(posedge clk); #1;
    drv(0, 0, 64'h40, 0, a0);
    wait_rsp(0, k, d, e);
    chk("err40_latency", k, 1);
    chk("err40_err", e, 1);
    @(posedge clk); #1;
    drv(1, 1, 64'h1_0000_0000, 64'hDEAD, a1);
    wait_rsp(1, k, d, e);
    chk("errhi_err", e, 1);

    // Both valid right after reset: req0 first, req1 right after req0's rsp, then alternate.
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    fork
      drv(0, 0, 64'd0, 0, a0);
      drv(1, 0, 64'd8, 0, a1);
    join
    chk("rr_first_req0", a0 < a1, 1);
    chk("rr_gap", a1 - a0, 10);
    repeat (9) @(posedge clk);
    #1;
    fork
      drv(0, 0, 64'd24, 0, a0);
      drv(1, 0, 64'd32, 0, a1);
    join
    chk("rr_alternate", a0 < a1, 1);
    repeat (10) @(posedge clk);
    #1;

    // Reset during beat 3 of a store to addr 0.
    drv(0, 1, 64'd0, 64'hF7F6F5F4F3F2F1F0, a0);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_norsp", rsp0_valid, 0);
    for (int i = 0; i < 8; i++) mv[8*i +: 8] = mem[i];
    chk("abort_mem", mv, 64'h07060504_03F2F1F0);
    @(posedge clk); #1;
    drv(1, 0, 64'd0, 0, a1);
    wait_rsp(1, k, d, e);
    chk("after_abort_latency", k, 9);
    chk("after_abort_data", d, 64'h07060504_03F2F1F0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
